// File: rtl/my_arith_pkg.sv
// Shared arithmetic definitions: serial-adder FSM states and default datapath sizing.
package my_arith_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/my_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the caller can derive two's-complement overflow on the top chunk.
module my_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    my_fulladder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/my_fulladder.sv
// One-bit full adder, the ripple element of the chunk adder.
module my_fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/my_serial_adder.sv
// Multi-cycle adder: adds WIDTH-bit operands CHUNK bits per clock, LSB chunk first,
// and publishes sum/cout/overflow only when the last chunk completes.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding one chunk per cycle, chunk index 0..N-1
// DONE  | results valid, done high; start here launches the next operation
module my_serial_adder
  import my_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SAFE_CHUNK = (CHUNK > 0) ? CHUNK : 1;
  localparam bit CFG_OK     = (CHUNK >= 1) && (CHUNK <= WIDTH) && ((WIDTH % SAFE_CHUNK) == 0);
  localparam int N          = WIDTH / SAFE_CHUNK;
  localparam int IDX_W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("my_serial_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
  end

  state_t           state_q, state_d;
  logic             load;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] op_a_q, op_b_q, work_q, work_next;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
  logic             ch_cout, ch_cmsb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Chunk select by shifting; the working register is cleared on load so the
  // new chunk can simply be OR'd into its slot.
  assign base      = 32'(idx_q) * 32'(CHUNK);
  assign ch_a      = CHUNK'(op_a_q >> base);
  assign ch_b      = CHUNK'(op_b_q >> base);
  assign work_next = work_q | (WIDTH'(ch_sum) << base);

  my_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (ch_a),
    .b     (ch_b),
    .cin   (carry_q),
    .sum   (ch_sum),
    .cout  (ch_cout),
    .c_msb (ch_cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      op_a_q  <= a;
      op_b_q  <= b;
      carry_q <= cin;
      idx_q   <= '0;
      work_q  <= '0;
    end else if (state_q == RUN) begin
      carry_q <= ch_cout;
      work_q  <= work_next;
      idx_q   <= idx_q + IDX_W'(1);
      // Only the final chunk publishes; intermediate results stay internal.
      if (idx_q == LAST_IDX) begin
        sum_q  <= work_next;
        cout_q <= ch_cout;
        ovf_q  <= ch_cmsb ^ ch_cout;
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: doc/my_serial_adder.md
MY_SERIAL_ADDER -- requirements
Module: my_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH mod CHUNK SHALL be 0 and CHUNK SHALL be in 1..WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE or DONE.
REQ-006 SHALL have port a  input  WIDTH  operand A, captured on accepted start.
REQ-007 SHALL have port b  input  WIDTH  operand B, captured on accepted start.
REQ-008 SHALL have port cin  input  1  carry-in, captured on accepted start.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port sum  output  WIDTH  registered result.
REQ-012 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-013 SHALL have port overflow  output  1  two's-complement overflow.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; N = WIDTH/CHUNK.
REQ-015 IDLE or DONE with start=1 SHALL capture a, b, cin, clear chunk index, and go to RUN; with start=0, DONE SHALL go to IDLE.
REQ-016 RUN SHALL add chunk [i*CHUNK +: CHUNK] of the captured operands plus the carry register, store the chunk result, and update the carry register each cycle, LSB chunk first.
REQ-017 After chunk N-1, RUN SHALL go to DONE; start high during RUN SHALL be ignored, and operands SHALL NOT be re-sampled.
REQ-018 With start high in cycle 0, done SHALL be high in cycle N+1 only (latency N+1); busy SHALL be high in cycles 1..N.
REQ-019 sum, cout, overflow SHALL update only on the RUN->DONE transition and hold until the next completed operation; partial results SHALL NOT be visible.
REQ-020 overflow SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-021 Addition SHALL be modulo 2^WIDTH, with the carry out reported on cout.
REQ-022 start in DONE SHALL be accepted: done high the same cycle, busy high next cycle (back-to-back throughput one result per N+1 cycles).
REQ-023 CHUNK=WIDTH SHALL give N=1: done in cycle 2.

Reset
REQ-024 rst high SHALL immediately force IDLE and drive busy=0, done=0, sum=0, cout=0, overflow=0, and clear the carry register and chunk index, regardless of clk.
REQ-025 rst asserted mid-RUN SHALL abandon the operation with no done pulse; first start after rst deasserts SHALL behave as from power-up.

Structure
REQ-026 The state enum (IDLE, RUN, DONE) SHALL live in shared package my_arith_pkg, alongside the default WIDTH/CHUNK constants.
REQ-027 Per-chunk addition SHALL be a combinational sub-module my_chunk_adder (CHUNK-bit ripple of my_fulladder instances, exposing the carry into its MSB for overflow).
REQ-028 The top SHALL contain only FSM, chunk index counter, operand/carry/result registers.
REQ-029 An illegal WIDTH/CHUNK combination SHALL be an elaboration-time error.

Verification
REQ-030 WIDTH=16, CHUNK=4, a=0x0001, b=0xFFFF, cin=0, start in cycle 0 -> done only in cycle 5, sum=0x0000, cout=1, overflow=0.
REQ-031 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1; then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, overflow=1.
REQ-032 Start a=0x1234, b=0x1111; pulse start with a=0xFFFF in cycle 2 -> ignored, sum=0x2345 in cycle 5.
REQ-033 rst asserted in cycle 3 of an operation -> outputs 0 at once, no done; next start a=5, b=3, cin=1 -> sum=0x0009.
REQ-034 start held high continuously -> done pulses in cycles 5, 10, 15, each with the operands captured at the accepting cycle.
REQ-035 CHUNK=16 build, a=0xFFFF, b=0x0000, cin=1 -> done in cycle 2, sum=0x0000, cout=1, overflow=0.
